// File: rtl/slice_scan_scheduler.sv
// Buffers one slice of NUM_BLOCKS quantized 8x8 blocks, then streams all DC
// coefficients followed by interleaved AC (run, level) pairs to the coders.
module slice_scan_scheduler #(
    parameter  int NUM_BLOCKS = 4,
    parameter  int COEFF_W    = 20,
    localparam int RUN_W      = $clog2(64 * NUM_BLOCKS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    input  logic               out_ready,
    output logic               dc_valid,
    output logic [COEFF_W-1:0] dc_coeff,
    output logic               ac_valid,
    output logic [RUN_W-1:0]   ac_run,
    output logic [COEFF_W-1:0] ac_level,
    output logic               enc_reset_n,
    output logic               busy,
    output logic               slice_done
);

    localparam int DEPTH = 64 * NUM_BLOCKS;
    localparam int AW    = RUN_W;
    localparam int BW    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CLR,
        S_DC,
        S_AC,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_waddr;
    logic [BW-1:0]      r_blk;
    logic [5:0]         r_pos;
    logic [RUN_W-1:0]   r_run;
    logic [COEFF_W-1:0] r_buf [DEPTH];

    state_t             w_next_state;
    logic [AW-1:0]      w_waddr_next;
    logic [BW-1:0]      w_blk_next;
    logic [5:0]         w_pos_next;
    logic [RUN_W-1:0]   w_run_next;
    logic [AW-1:0]      w_raddr;
    logic [COEFF_W-1:0] w_rdata;
    logic               w_last_blk;
    logic               w_we;

    // r_pos is held at 0 through DC so the same address serves both phases.
    assign w_raddr    = AW'({r_blk, r_pos});
    assign w_rdata    = r_buf[w_raddr];
    assign w_last_blk = (r_blk == BW'(NUM_BLOCKS - 1));

    always_comb begin
        w_next_state = r_state;
        w_waddr_next = r_waddr;
        w_blk_next   = r_blk;
        w_pos_next   = r_pos;
        w_run_next   = r_run;
        w_we         = 1'b0;
        in_ready     = 1'b0;
        dc_valid     = 1'b0;
        dc_coeff     = '0;
        ac_valid     = 1'b0;
        ac_run       = '0;
        ac_level     = '0;
        enc_reset_n  = 1'b1;
        busy         = 1'b1;
        slice_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_we         = 1'b1;
                    w_waddr_next = r_waddr + AW'(1);
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_we = 1'b1;
                    if (r_waddr == AW'(DEPTH - 1)) begin
                        w_waddr_next = '0;
                        w_next_state = S_CLR;
                    end else begin
                        w_waddr_next = r_waddr + AW'(1);
                    end
                end
            end
            S_CLR: begin
                enc_reset_n  = 1'b0;
                w_blk_next   = '0;
                w_pos_next   = '0;
                w_next_state = S_DC;
            end
            S_DC: begin
                dc_valid = 1'b1;
                dc_coeff = w_rdata;
                if (out_ready) begin
                    if (w_last_blk) begin
                        w_blk_next   = '0;
                        w_pos_next   = 6'd1;
                        w_run_next   = '0;
                        w_next_state = S_AC;
                    end else begin
                        w_blk_next = r_blk + BW'(1);
                    end
                end
            end
            S_AC: begin
                // Zero entries only bump the run; a nonzero one stalls the scan until taken.
                if (w_rdata != '0) begin
                    ac_valid = 1'b1;
                    ac_run   = r_run;
                    ac_level = w_rdata;
                end
                if ((w_rdata == '0) || out_ready) begin
                    w_run_next = (w_rdata == '0) ? (r_run + RUN_W'(1)) : '0;
                    if (w_last_blk) begin
                        w_blk_next = '0;
                        if (r_pos == 6'd63) begin
                            w_pos_next   = '0;
                            w_next_state = S_DONE;
                        end else begin
                            w_pos_next = r_pos + 6'd1;
                        end
                    end else begin
                        w_blk_next = r_blk + BW'(1);
                    end
                end
            end
            S_DONE: begin
                slice_done   = 1'b1;
                w_blk_next   = '0;
                w_pos_next   = '0;
                w_run_next   = '0;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (!reset_n) begin
            w_we        = 1'b0;
            in_ready    = 1'b0;
            dc_valid    = 1'b0;
            dc_coeff    = '0;
            ac_valid    = 1'b0;
            ac_run      = '0;
            ac_level    = '0;
            enc_reset_n = 1'b0;
            busy        = 1'b0;
            slice_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_waddr <= '0;
            r_blk   <= '0;
            r_pos   <= '0;
            r_run   <= '0;
        end else begin
            r_state <= w_next_state;
            r_waddr <= w_waddr_next;
            r_blk   <= w_blk_next;
            r_pos   <= w_pos_next;
            r_run   <= w_run_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_buf[r_waddr] <= in_coeff;
        end
    end

endmodule

// File: tb/tb_slice_scan_scheduler.sv
// Randomized bench for slice_scan_scheduler: a queue-based slice model predicts
// the DC list and the interleaved (run, level) list, checked beat by beat.
module tb_slice_scan_scheduler;

    localparam int NB    = 4;
    localparam int CW    = 20;
    localparam int RW    = $clog2(64 * NB);
    localparam int LIMIT = 3000;

    typedef struct {
        int run;
        int level;
    } acBeat_t;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_coeff;
    logic          out_ready;
    logic          dc_valid;
    logic [CW-1:0] dc_coeff;
    logic          ac_valid;
    logic [RW-1:0] ac_run;
    logic [CW-1:0] ac_level;
    logic          enc_reset_n;
    logic          busy;
    logic          slice_done;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit bpMode     = 0;

    int      sl [NB][64];
    int      expDc [$];
    acBeat_t expAc [$];
    int      slicePending [$];
    acBeat_t acLog [$];
    int      dcEdges [$];
    int      encPulses  = 0;
    int      expPulses  = 0;
    int      doneCount  = 0;
    int      acAccepts  = 0;
    int      doneEdge   = 0;
    int      lastDcEdge = 0;

    slice_scan_scheduler #(.NUM_BLOCKS(NB), .COEFF_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coeff   (in_coeff),
        .out_ready  (out_ready),
        .dc_valid   (dc_valid),
        .dc_coeff   (dc_coeff),
        .ac_valid   (ac_valid),
        .ac_run     (ac_run),
        .ac_level   (ac_level),
        .enc_reset_n(enc_reset_n),
        .busy       (busy),
        .slice_done (slice_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Downstream readiness: always ready unless backpressure is enabled or reset is held.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (bpMode || !reset_n) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors = vectors + 1;
        if (observed !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic finishRun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Output monitor: scoreboards accepted beats and checks handshake rules every cycle.
    initial begin
        bit            prevDcStall = 0;
        bit            prevAcStall = 0;
        logic [CW-1:0] prevDcCoeff = '0;
        logic [RW-1:0] prevAcRun   = '0;
        logic [CW-1:0] prevAcLevel = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prevDcStall = 0;
                prevAcStall = 0;
            end else begin
                if (!enc_reset_n) encPulses = encPulses + 1;
                if (dc_valid || ac_valid || slice_done || !enc_reset_n)
                    checkOutput("inReadyWhileBusy", in_ready, 0);
                if (dc_valid || ac_valid)
                    checkOutput("validExclusive", dc_valid && ac_valid, 0);
                if (prevDcStall) begin
                    checkOutput("dcHold", dc_valid, 1);
                    checkOutput("dcStable", dc_coeff, prevDcCoeff);
                end
                if (prevAcStall) begin
                    checkOutput("acHold", ac_valid, 1);
                    checkOutput("acRunStable", ac_run, prevAcRun);
                    checkOutput("acLevelStable", ac_level, prevAcLevel);
                end
                if (dc_valid && out_ready) begin
                    dcEdges.push_back(cyc + 1);
                    lastDcEdge = cyc + 1;
                    checkOutput("dcPending", expDc.size() > 0, 1);
                    if (expDc.size() > 0) checkOutput("dcCoeff", $signed(dc_coeff), expDc.pop_front());
                    if (slicePending.size() > 0) slicePending[0] = slicePending[0] - 1;
                end
                if (ac_valid && out_ready) begin
                    acBeat_t e;
                    acAccepts = acAccepts + 1;
                    acLog.push_back('{int'(ac_run), int'($signed(ac_level))});
                    checkOutput("acPending", expAc.size() > 0, 1);
                    if (expAc.size() > 0) begin
                        e = expAc.pop_front();
                        checkOutput("acRun", ac_run, e.run);
                        checkOutput("acLevel", $signed(ac_level), e.level);
                    end
                    if (slicePending.size() > 0) slicePending[0] = slicePending[0] - 1;
                end
                if (slice_done) begin
                    doneCount = doneCount + 1;
                    doneEdge  = cyc;
                    checkOutput("sliceBeatsLeft", (slicePending.size() > 0) ? slicePending[0] : -1, 0);
                    if (slicePending.size() > 0) void'(slicePending.pop_front());
                end
                prevDcStall = dc_valid && !out_ready;
                prevAcStall = ac_valid && !out_ready;
                prevDcCoeff = dc_coeff;
                prevAcRun   = ac_run;
                prevAcLevel = ac_level;
            end
        end
    end

    // Reference model: DCs in block order, then AC scanned position-major, block-minor.
    task automatic buildExpected();
        int run   = 0;
        int beats = NB;
        for (int b = 0; b < NB; b++) expDc.push_back(sl[b][0]);
        for (int p = 1; p < 64; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (sl[b][p] == 0) begin
                    run = run + 1;
                end else begin
                    expAc.push_back('{run, sl[b][p]});
                    run   = 0;
                    beats = beats + 1;
                end
            end
        end
        slicePending.push_back(beats);
    endtask

    function automatic int randCoeff();
        int v;
        if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 30)) - 15;
        else                           v = int'($urandom) >>> 12;
        return (v == 0) ? 1 : v;
    endfunction

    task automatic randomSlice(input int zeroPct);
        for (int b = 0; b < NB; b++) begin
            sl[b][0] = int'($urandom) >>> 12;
            for (int p = 1; p < 64; p++)
                sl[b][p] = (int'($urandom_range(0, 99)) < zeroPct) ? 0 : randCoeff();
        end
    endtask

    task automatic feedBeat(input int v);
        int w = 0;
        in_valid = 1'b1;
        in_coeff = v[CW-1:0];
        @(negedge clk);
        while (!in_ready && w < LIMIT) begin
            @(negedge clk);
            w = w + 1;
        end
        if (w >= LIMIT) begin
            checkOutput("inReadyWait", w, 0);
            finishRun();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit holdValid, input bit gaps);
        buildExpected();
        expPulses = expPulses + 1;
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < 64; p++) begin
                if (gaps && $urandom_range(0, 7) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                feedBeat(sl[b][p]);
            end
        end
        if (!holdValid) in_valid = 1'b0;
        @(negedge clk);
        checkOutput("clrEncReset", enc_reset_n, 0);
        checkOutput("clrBusy", busy, 1);
        @(negedge clk);
        checkOutput("firstDcValid", dc_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int target);
        int w = 0;
        while (doneCount < target && w < LIMIT) begin
            @(posedge clk);
            w = w + 1;
        end
        checkOutput("doneReached", doneCount >= target, 1);
        if (doneCount < target) finishRun();
        #1;
        checkOutput("encPulses", encPulses, expPulses);
    endtask

    task automatic doReset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_coeff = CW'($urandom);
            @(negedge clk);
            checkOutput("rstInReady", in_ready, 0);
            checkOutput("rstDcValid", dc_valid, 0);
            checkOutput("rstAcValid", ac_valid, 0);
            checkOutput("rstDcCoeff", dc_coeff, 0);
            checkOutput("rstAcRun", ac_run, 0);
            checkOutput("rstAcLevel", ac_level, 0);
            checkOutput("rstEncReset", enc_reset_n, 0);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstSliceDone", slice_done, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        expDc.delete();
        expAc.delete();
        slicePending.delete();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("postRstInReady", in_ready, 1);
        checkOutput("postRstEncReset", enc_reset_n, 1);
        checkOutput("postRstBusy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic zeroSlice();
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < 64; p++) sl[b][p] = 0;
    endtask

    initial begin
        int base;
        int w;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_coeff = '0;

        doReset(3);

        // DC only, every AC zero, no backpressure.
        zeroSlice();
        for (int b = 0; b < NB; b++) sl[b][0] = 100 + b;
        dcEdges.delete();
        base = acAccepts;
        applyStimulus(0, 0);
        waitDone(doneCount + 1);
        checkOutput("dcCount", dcEdges.size(), NB);
        if (dcEdges.size() == NB) checkOutput("dcConsecutive", dcEdges[NB-1] - dcEdges[0], NB - 1);
        checkOutput("noAcBeats", acAccepts - base, 0);
        checkOutput("doneLatency", doneEdge - lastDcEdge, 63 * NB);

        // Sparse AC pattern with runs crossing block boundaries.
        for (int pass = 0; pass < 2; pass++) begin
            bpMode = (pass == 1);
            zeroSlice();
            for (int b = 0; b < NB; b++) sl[b][0] = 10 * b - 7;
            sl[0][1] = 5;
            sl[2][1] = -3;
            sl[1][2] = 7;
            acLog.delete();
            applyStimulus(0, pass == 1);
            waitDone(doneCount + 1);
            checkOutput("directedAcCount", acLog.size(), 3);
            if (acLog.size() == 3) begin
                checkOutput("directedRun0", acLog[0].run, 0);
                checkOutput("directedLevel0", acLog[0].level, 5);
                checkOutput("directedRun1", acLog[1].run, 1);
                checkOutput("directedLevel1", acLog[1].level, -3);
                checkOutput("directedRun2", acLog[2].run, 2);
                checkOutput("directedLevel2", acLog[2].level, 7);
            end
        end

        // Random slices under random backpressure and input gaps.
        bpMode = 1;
        for (int s = 0; s < 3; s++) begin
            randomSlice((s == 0) ? 95 : 70);
            applyStimulus(0, 1);
            waitDone(doneCount + 1);
        end

        // Abandon a slice mid-AC, idle, then run a fresh slice.
        randomSlice(80);
        sl[0][5] = 9;
        base = acAccepts;
        applyStimulus(0, 0);
        w = 0;
        while (acAccepts == base && w < LIMIT) begin
            @(posedge clk);
            w = w + 1;
        end
        checkOutput("acStartedBeforeReset", acAccepts > base, 1);
        #1;
        base = doneCount;
        doReset(2);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("noDoneAfterAbort", doneCount, base);
        randomSlice(60);
        applyStimulus(0, 1);
        waitDone(doneCount + 1);

        // Back-to-back slices with in_valid never dropped. The held beat becomes
        // the next slice's first coefficient, so slice 2 starts with that value.
        base = doneCount;
        randomSlice(75);
        applyStimulus(1, 0);
        w = sl[NB-1][63];
        randomSlice(75);
        sl[0][0] = w;
        applyStimulus(0, 0);
        waitDone(base + 2);

        in_valid = 1'b0;
        bpMode = 0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("finalIdleBusy", busy, 0);
        finishRun();
    end

endmodule
